// File: rtl/rl_ram_1r1w_clr_ctrl.sv
// Controller for a 1R1W RAM: clears every location to INIT_VALUE after reset
// and on request, then passes user traffic through. Adds a read-valid strobe
// and merges same-cycle write data into the read result, because the RAM's
// own same-address read-during-write result is undefined.
module rl_ram_1r1w_clr_ctrl #(
    parameter int               ABITS      = 10,
    parameter int               DBITS      = 32,
    parameter logic [DBITS-1:0] INIT_VALUE = {DBITS{1'b0}},
    parameter bit               AUTO_INIT  = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    output logic                     busy_o,
    input  logic [ABITS-1:0]         waddr_i,
    input  logic [DBITS-1:0]         din_i,
    input  logic [(DBITS+7)/8-1:0]   be_i,
    input  logic                     we_i,
    input  logic [ABITS-1:0]         raddr_i,
    input  logic                     re_i,
    output logic [DBITS-1:0]         dout_o,
    output logic                     dout_vld_o,
    output logic [ABITS-1:0]         ram_waddr_o,
    output logic [DBITS-1:0]         ram_din_o,
    output logic [(DBITS+7)/8-1:0]   ram_be_o,
    output logic                     ram_we_o,
    output logic [ABITS-1:0]         ram_raddr_o,
    input  logic [DBITS-1:0]         ram_dout_i
);

    localparam int               BBITS     = (DBITS + 7) / 8;
    localparam logic [ABITS-1:0] LAST_ADDR = {ABITS{1'b1}};

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    localparam state_t RESET_STATE = AUTO_INIT ? ST_CLEAR : ST_RUN;

    state_t           state;
    state_t           state_nxt;
    logic [ABITS-1:0] cnt;
    logic             rd_acc;
    logic             fwd_hit;
    logic [DBITS-1:0] fwd_din;
    logic [BBITS-1:0] fwd_be;
    logic [DBITS-1:0] held;
    logic [DBITS-1:0] merged;

    // A read counts only in RUN; forwarding applies when it collides with a write.
    assign rd_acc  = (state == ST_RUN) && re_i;
    assign fwd_hit = rd_acc && we_i && (waddr_i == raddr_i);

    // State register.
    // NOTE: sequential state is always updated with non-blocking assignments so
    // every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= RESET_STATE;
        else       state <= state_nxt;
    end

    // Next-state logic: clear runs to the last address, clr_i restarts it from RUN.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLEAR: if (cnt == LAST_ADDR) state_nxt = ST_RUN;
            ST_RUN:   if (clr_i)            state_nxt = ST_CLEAR;
            default:                        state_nxt = RESET_STATE;
        endcase
    end

    // Clear address counter; wraps back to 0 on the final clear write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                  cnt <= '0;
        else if (state == ST_CLEAR) cnt <= cnt + 1'b1;
    end

    // Read-valid strobe and captured write data for the read-during-write forward.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dout_vld_o <= 1'b0;
            fwd_din    <= '0;
            fwd_be     <= '0;
        end else begin
            dout_vld_o <= rd_acc;
            fwd_be     <= fwd_hit ? be_i : '0;
            if (fwd_hit) fwd_din <= din_i;
        end
    end

    // Byte merge of forwarded write data over the RAM read data.
    // NOTE: every combinational output gets a default before any branch so no
    // latch can be inferred when a path leaves it unassigned.
    always_comb begin
        merged = ram_dout_i;
        for (int i = 0; i < DBITS; i++) begin
            if (fwd_be[i/8]) merged[i] = fwd_din[i];
        end
    end

    // Hold the last delivered read so dout_o stays stable between reads.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)           held <= '0;
        else if (dout_vld_o) held <= merged;
    end

    assign dout_o = dout_vld_o ? merged : held;

    // Output logic: clear writes during CLEAR, user pass-through during RUN.
    always_comb begin
        busy_o      = 1'b0;
        ram_we_o    = we_i;
        ram_waddr_o = waddr_i;
        ram_din_o   = din_i;
        ram_be_o    = be_i;
        ram_raddr_o = raddr_i;
        if (state == ST_CLEAR) begin
            busy_o      = 1'b1;
            ram_we_o    = 1'b1;
            ram_waddr_o = cnt;
            ram_din_o   = INIT_VALUE;
            ram_be_o    = {BBITS{1'b1}};
        end
    end

endmodule

// File: doc/rl_ram_1r1w_clr_ctrl.md
# rl_ram_1r1w_clr_ctrl

Controller that drives the write and read ports of a technology-specific 1R1W RAM, such as the Lattice dual-port RAM wrapper. After reset, and again on request, it clears every RAM location to a programmable value. Once clear, it passes user write and read traffic through to the RAM. On the read side it adds a valid strobe and a read-during-write forward, because the RAM's same-address read-during-write result is undefined.

## Interface
- ABITS, 10, address width; RAM depth is 2^ABITS.
- DBITS, 32, data width; byte enables are (DBITS+7)/8 bits wide.
- INIT_VALUE, {DBITS{1'b0}}, value written to every location during a clear.
- AUTO_INIT, 1, when 1 a clear starts automatically on reset release; when 0 the block comes out of reset in RUN.

Ports:
- clk_i  in  1  clock, rising edge; also drives the RAM read and write clocks.
- rst_i  in  1  reset, asynchronous, active-high.
- clr_i  in  1  clear request, sampled in RUN only.
- busy_o  out  1  high while a clear is in progress; user accesses are ignored while it is high.
- waddr_i / din_i / be_i / we_i  in  ABITS / DBITS / (DBITS+7)/8 / 1  user write port.
- raddr_i / re_i  in  ABITS / 1  user read request.
- dout_o  out  DBITS  read data.
- dout_vld_o  out  1  dout_o carries the result of the read accepted in the previous cycle.
- ram_waddr_o / ram_din_o / ram_be_o / ram_we_o  out  ABITS / DBITS / (DBITS+7)/8 / 1  RAM write port.
- ram_raddr_o  out  ABITS  RAM read address.
- ram_dout_i  in  DBITS  RAM read data; registered, valid one cycle after the address is presented.

## Operation
- State machine with two states: CLEAR and RUN.
- Reset state:
  - CLEAR if AUTO_INIT=1, otherwise RUN.
  - Address counter = 0, dout_vld_o = 0, held-data register = 0.
- CLEAR:
  - ram_we_o = 1, ram_waddr_o = counter, ram_din_o = INIT_VALUE, ram_be_o = all ones.
  - Counter increments every cycle.
  - When the counter reaches 2^ABITS-1: the counter wraps to 0 and the state moves to RUN on the next edge.
  - we_i, re_i and clr_i are ignored; a clr_i during CLEAR does not restart the clear.
- RUN:
  - RAM write port is a combinational pass-through of the user write port (ram_we_o = we_i).
  - ram_raddr_o = raddr_i in every state.
  - clr_i=1 moves the state to CLEAR on the next edge, starting at address 0.
  - User accesses presented in the same cycle as clr_i are still performed.
- Read acceptance: a read is accepted when re_i=1 in RUN. An accepted read sets dout_vld_o=1 in the next cycle.
- Forwarding:
  - Applies when an accepted read has we_i=1 and waddr_i==raddr_i in the same cycle.
  - The block registers din_i and be_i.
  - Next cycle, each byte of dout_o with its be bit set comes from the registered din_i; all other bytes come from ram_dout_i.
- Read data:
  - When dout_vld_o=1, dout_o = the merged data and is captured into the held register.
  - When dout_vld_o=0, dout_o = the held register, which does not change.
- Asynchronous reset at any time, including mid-clear, returns every register to its reset state; with AUTO_INIT=1 the clear restarts at address 0.

## Timing
- busy_o is high for exactly 2^ABITS cycles per clear.
  - After reset release with AUTO_INIT=1: from the first clock edge until the edge that writes address 2^ABITS-1.
  - After clr_i: rises on the edge following the cycle in which clr_i is sampled.
- Read latency: 1 cycle from re_i to dout_vld_o / dout_o, including forwarded reads.
- A read accepted in the last RUN cycle before CLEAR completes normally (dout_vld_o=1 in the first CLEAR cycle).
- User writes reach the RAM with zero added latency. A write is readable on the next cycle's read without forwarding.

## Test plan
- ABITS=4, INIT_VALUE=32'hDEADBEEF, AUTO_INIT=1, release rst_i:
  - ram_we_o high for 16 cycles with ram_waddr_o stepping 0..15, then busy_o=0.
  - Reading addresses 0..15 returns 32'hDEADBEEF.
- In RUN, write 32'h12345678 to address 3 with be=4'hF. Read address 3 the next cycle -> dout_vld_o=1 one cycle later, dout_o=32'h12345678.
- Address 7 holds 32'hAAAAAAAA. In one cycle, write 32'h11223344 to address 7 with be=4'b0011 and read address 7 -> next cycle dout_o=32'hAAAA3344.
- Pulse clr_i in RUN together with a read:
  - The read completes.
  - busy_o rises the next cycle and stays high 16 cycles.
  - re_i/we_i pulses during busy_o produce no ram_we_o and no dout_vld_o.
  - dout_o holds its last value.
- Assert rst_i at clear address 9 -> outputs return to reset values immediately. After release, the clear restarts at address 0 and lasts 16 cycles.
- AUTO_INIT=0: after reset, busy_o=0 and a write/read pair works immediately.
